move_executor: RTL
==================

# move_executor

Sequential consumer of the per-square move mask: turns player square clicks into committed moves on the game board. Owns the authoritative 8x8 board register and the side-to-move flag. Feeds the selected figure and square to the move-logic block, waits for its registered mask, checks the destination against it, then writes the board. Sits between the mouse/click decoder and the board renderer.

## Interface
- MASK_LAT, default 1, cycles from sel_figure/sel_position stable to possible_moves valid (1..7)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- click_valid  in  1  one-cycle pulse, a square was clicked
- click_pos  in  6  clicked square, [5:3] row, [2:0] col
- click_ready  out  1  high when a click is accepted this cycle
- possible_moves  in  64  mask from move logic; square {row,col} is bit 63-{row,col}
- sel_figure  out  4  figure code on the selected source square (0 when none)
- sel_position  out  6  selected source square
- board  out  4x8x8  board register, [row][col]
- turn  out  1  0 white to move, 1 black
- move_done  out  1  one-cycle pulse after a commit
- move_illegal  out  1  one-cycle pulse on a rejected destination
- game_over  out  1  sticky, set when a king is captured

## Operation
- Codes: 0 empty; white 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king; black 7..12 same order. Own piece: white 1..6, black 7..12.
- Reset layout: row 0 black back rank, row 1 black pawns, row 6 white pawns, row 7 white back rank; back rank col0..7 rook, knight, bishop, queen, king, bishop, knight, rook.
- States: IDLE, WAIT_MASK, DST_SEL, COMMIT, OVER.
- IDLE: click on own piece -> latch sel_position, sel_figure, load wait counter, go WAIT_MASK. Empty or opponent square -> ignored, stay.
- WAIT_MASK: counter from MASK_LAT down; at 0 latch possible_moves into internal mask, go DST_SEL. Clicks not accepted.
- DST_SEL: click on same square -> deselect, sel_figure=0, IDLE. Click on other own piece -> reselect, WAIT_MASK. Mask bit set -> COMMIT. Otherwise move_illegal pulse, stay DST_SEL.
- COMMIT (1 cycle): board[dst]=sel_figure, board[src]=0, toggle turn, pulse move_done, clear selection. Captured code 6 or 12 -> game_over=1, OVER; else IDLE.
- OVER: no clicks accepted, board frozen until rst.
- Mask width rule: bit index computed as 63 - {row,col} in 6 bits, no wrap.

## Timing
- Reset values: board = initial layout, turn=0, sel_figure=0, sel_position=0, move_done=0, move_illegal=0, game_over=0, click_ready=1, state IDLE.
- click_ready high only in IDLE and DST_SEL; click_valid while low is dropped.
- Source click at cycle N -> sel_* valid N+1; mask sampled N+1+MASK_LAT.
- Destination click at cycle M -> board, turn, move_done updated at M+2 (COMMIT registered at M+1, outputs at M+2); move_illegal at M+1.
- rst mid-operation: any state returns to IDLE, layout reloaded, pending selection lost.
- sel_figure/sel_position held stable from WAIT_MASK through DST_SEL.

## Configuration
- PAWN_PROMOTION_EN defined: in COMMIT, code 1 arriving at row 0 writes 5; code 7 arriving at row 7 writes 11.
- Undefined: pawn written unchanged on any row.

## Structure
- Shared package chess_pkg: figure code localparams (EMPTY, W_PAWN..B_KING), is_white/is_black functions, initial layout constant, state enum.
- One sub-module natural: board_init_rom (combinational layout constant per square), used on reset.

## Test plan
- Reset then read board: board[7][4]=6, board[0][3]=11, board[6][0]=1, board[4][4]=0; turn=0, click_ready=1.
- Click 52 (row6 col4), mask with bit 63-36 set, click 36 -> board[4][4]=1, board[6][4]=0, move_done pulse, turn=1.
- White to move, click black pawn square 8 -> ignored, state IDLE, sel_figure=0.
- Select square 52, click 20 with bit clear -> move_illegal pulse, board unchanged, still DST_SEL; click 52 -> deselect.
- Preload black king reachable; commit capture -> game_over=1, further click_valid ignored, click_ready=0; rst restores layout.
- With PAWN_PROMOTION_EN: white pawn on 8 moves to 0 -> board[0][0]=5; without macro -> 1.

Source files
------------

// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared definitions for the chess move executor:
//   - figure codes (EMPTY, W_PAWN..W_KING = 1..6, B_PAWN..B_KING = 7..12)
//   - back-rank layout constants for both colours
//   - colour helper functions is_white / is_black
//   - init_code(): initial board layout for one square ({row,col})
//   - state_t: move executor FSM states
// -----------------------------------------------------------------------------
package chess_pkg;

    localparam logic [3:0] EMPTY    = 4'd0;
    localparam logic [3:0] W_PAWN   = 4'd1;
    localparam logic [3:0] W_ROOK   = 4'd2;
    localparam logic [3:0] W_KNIGHT = 4'd3;
    localparam logic [3:0] W_BISHOP = 4'd4;
    localparam logic [3:0] W_QUEEN  = 4'd5;
    localparam logic [3:0] W_KING   = 4'd6;
    localparam logic [3:0] B_PAWN   = 4'd7;
    localparam logic [3:0] B_ROOK   = 4'd8;
    localparam logic [3:0] B_KNIGHT = 4'd9;
    localparam logic [3:0] B_BISHOP = 4'd10;
    localparam logic [3:0] B_QUEEN  = 4'd11;
    localparam logic [3:0] B_KING   = 4'd12;

    // Back rank, indexed by column 0..7 (ascending range so element 0 is col 0)
    localparam logic [0:7][3:0] BACK_RANK_W = {W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN,
                                               W_KING, W_BISHOP, W_KNIGHT, W_ROOK};
    localparam logic [0:7][3:0] BACK_RANK_B = {B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN,
                                               B_KING, B_BISHOP, B_KNIGHT, B_ROOK};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MASK,
        S_DST_SEL,
        S_COMMIT,
        S_OVER
    } state_t;

    function automatic logic is_white(input logic [3:0] code);
        return (code >= W_PAWN) && (code <= W_KING);
    endfunction

    function automatic logic is_black(input logic [3:0] code);
        return (code >= B_PAWN) && (code <= B_KING);
    endfunction

    // Initial layout: black occupies rows 0/1, white rows 6/7
    function automatic logic [3:0] init_code(input logic [5:0] pos);
        logic [3:0] code;
        case (pos[5:3])
            3'd0:    code = BACK_RANK_B[pos[2:0]];
            3'd1:    code = B_PAWN;
            3'd6:    code = W_PAWN;
            3'd7:    code = BACK_RANK_W[pos[2:0]];
            default: code = EMPTY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/board_init_rom.sv
// -----------------------------------------------------------------------------
// board_init_rom
// Combinational initial-layout lookup for a single square.
// Ports:
//   i_pos  [5:0]  square {row[2:0], col[2:0]}
//   o_code [3:0]  figure code at that square in the starting position
// -----------------------------------------------------------------------------
module board_init_rom
    import chess_pkg::*;
(
    input  logic [5:0] i_pos,
    output logic [3:0] o_code
);

    assign o_code = init_code(i_pos);

endmodule

// File: rtl/move_executor.sv
// -----------------------------------------------------------------------------
// move_executor
// Turns square clicks into committed moves. Owns the 8x8 board and the
// side-to-move flag; hands the selected figure/square to the external
// move-logic block, waits MASK_LAT cycles for its mask, validates the
// destination click against that mask and writes the board.
//
// Optional feature macro: PAWN_PROMOTION_EN
//   defined   -> a white pawn reaching row 0 becomes a white queen, a black
//                pawn reaching row 7 becomes a black queen
//   undefined -> pawns are written unchanged
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   click_valid    in   one-cycle click pulse
//   click_pos      in   clicked square {row,col}
//   click_ready    out  click accepted this cycle (IDLE / DST_SEL only)
//   possible_moves in   mask from move logic, square s is bit 63-s
//   sel_figure     out  selected figure code (0 when none)
//   sel_position   out  selected source square
//   board          out  board register, board[row][col]
//   turn           out  0 white to move, 1 black
//   move_done      out  one-cycle pulse after a commit
//   move_illegal   out  one-cycle pulse on a rejected destination
//   game_over      out  sticky, set when a king is captured
// -----------------------------------------------------------------------------
module move_executor
    import chess_pkg::*;
#(
    parameter int MASK_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       click_valid,
    input  logic [5:0]                 click_pos,
    output logic                       click_ready,
    input  logic [63:0]                possible_moves,
    output logic [3:0]                 sel_figure,
    output logic [5:0]                 sel_position,
    output logic [7:0][7:0][3:0]       board,
    output logic                       turn,
    output logic                       move_done,
    output logic                       move_illegal,
    output logic                       game_over
);

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0][7:0][3:0] r_board;
    logic [7:0][7:0][3:0] w_init_board;
    logic                 r_turn;
    logic [3:0]           r_sel_fig;
    logic [5:0]           r_sel_pos;
    logic [5:0]           r_dst;
    logic [63:0]          r_mask;
    logic [2:0]           r_cnt;
    logic                 r_done;
    logic                 r_illegal;
    logic                 r_over;

    logic                 w_accept;
    logic [3:0]           w_click_fig;
    logic                 w_click_own;
    logic                 w_load_sel;
    logic                 w_clear_sel;
    logic                 w_load_mask;
    logic                 w_set_dst;
    logic                 w_illegal;
    logic [3:0]           w_captured;
    logic [3:0]           w_write_fig;

    // Starting layout, one ROM lookup per square
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_init
            board_init_rom u_rom (
                .i_pos  (6'(gi)),
                .o_code (w_init_board[gi / 8][gi % 8])
            );
        end
    endgenerate

    assign click_ready = (r_state == S_IDLE) || (r_state == S_DST_SEL);
    assign w_accept    = click_valid && click_ready;
    assign w_click_fig = r_board[click_pos[5:3]][click_pos[2:0]];
    assign w_click_own = r_turn ? is_black(w_click_fig) : is_white(w_click_fig);
    assign w_captured  = r_board[r_dst[5:3]][r_dst[2:0]];

`ifdef PAWN_PROMOTION_EN
    always_comb begin
        w_write_fig = r_sel_fig;
        if ((r_sel_fig == W_PAWN) && (r_dst[5:3] == 3'd0))
            w_write_fig = W_QUEEN;
        else if ((r_sel_fig == B_PAWN) && (r_dst[5:3] == 3'd7))
            w_write_fig = B_QUEEN;
    end
`else
    assign w_write_fig = r_sel_fig;
`endif

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_load_sel   = 1'b0;
        w_clear_sel  = 1'b0;
        w_load_mask  = 1'b0;
        w_set_dst    = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_click_own) begin
                    w_load_sel   = 1'b1;
                    w_next_state = S_WAIT_MASK;
                end
            end
            S_WAIT_MASK: begin
                if (r_cnt == 3'd0) begin
                    w_load_mask  = 1'b1;
                    w_next_state = S_DST_SEL;
                end
            end
            S_DST_SEL: begin
                if (w_accept) begin
                    if (click_pos == r_sel_pos) begin
                        w_clear_sel  = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (w_click_own) begin
                        w_load_sel   = 1'b1;
                        w_next_state = S_WAIT_MASK;
                    end else if (r_mask[6'd63 - click_pos]) begin
                        w_set_dst    = 1'b1;
                        w_next_state = S_COMMIT;
                    end else begin
                        w_illegal    = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                w_next_state = ((w_captured == W_KING) || (w_captured == B_KING))
                             ? S_OVER : S_IDLE;
            end
            S_OVER:  w_next_state = S_OVER;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_board   <= w_init_board;
            r_turn    <= 1'b0;
            r_sel_fig <= EMPTY;
            r_sel_pos <= 6'd0;
            r_dst     <= 6'd0;
            r_mask    <= 64'd0;
            r_cnt     <= 3'd0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_done    <= 1'b0;
            r_illegal <= w_illegal;

            if (w_load_sel) begin
                r_sel_pos <= click_pos;
                r_sel_fig <= w_click_fig;
                r_cnt     <= 3'(MASK_LAT);
            end else if ((r_state == S_WAIT_MASK) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_load_mask)
                r_mask <= possible_moves;
            if (w_set_dst)
                r_dst <= click_pos;
            if (w_clear_sel) begin
                r_sel_fig <= EMPTY;
                r_sel_pos <= 6'd0;
            end

            if (r_state == S_COMMIT) begin
                r_board[r_dst[5:3]][r_dst[2:0]]         <= w_write_fig;
                r_board[r_sel_pos[5:3]][r_sel_pos[2:0]] <= EMPTY;
                r_turn    <= ~r_turn;
                r_done    <= 1'b1;
                r_sel_fig <= EMPTY;
                r_sel_pos <= 6'd0;
                if ((w_captured == W_KING) || (w_captured == B_KING))
                    r_over <= 1'b1;
            end
        end
    end

    assign sel_figure   = r_sel_fig;
    assign sel_position = r_sel_pos;
    assign board        = r_board;
    assign turn         = r_turn;
    assign move_done    = r_done;
    assign move_illegal = r_illegal;
    assign game_over    = r_over;

endmodule
